// File: rtl/regfile_scoreboard.sv
// Multi-read-port integer register file with write-first bypass, hardwired x0
// and a per-register busy scoreboard that flags RAW hazards to the hazard unit.
module regfile_scoreboard #(
  parameter int XLEN   = 64,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int RD_LAT = 0,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_RD*AW-1:0]   rs_addr_i,
  output logic [NUM_RD*XLEN-1:0] rs_data_o,
  output logic [NUM_RD-1:0]      rs_busy_o,
  input  logic                   wb_en_i,
  input  logic [AW-1:0]          wb_addr_i,
  input  logic [XLEN-1:0]        wb_data_i,
  input  logic                   iss_en_i,
  input  logic [AW-1:0]          iss_addr_i,
  input  logic                   flush_i,
  output logic [AW:0]            busy_cnt_o
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW:0]      busy_cnt_q;
  logic             wb_we;

  assign wb_we = wb_en_i && (wb_addr_i != '0);

  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int k = 0; k < NREGS; k++) begin
      c = c + {{AW{1'b0}}, v[k]};
    end
    return c;
  endfunction

  // x0 is never written, so regs_q[0] stays at its reset value of zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= '0;
      end
    end else if (wb_we) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  // Priority: flush clears all, then issue sets, then writeback clears.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (flush_i) begin
        busy_d[r] = 1'b0;
      end else if (iss_en_i && (iss_addr_i == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wb_en_i && (wb_addr_i == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= popcount(busy_d);
    end
  end

  assign busy_cnt_o = busy_cnt_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            hit_wb;
    logic            hit_iss;
    logic [XLEN-1:0] data_c;
    logic            busy_c;

    assign addr    = rs_addr_i[i*AW +: AW];
    assign hit_wb  = wb_en_i && (wb_addr_i == addr);
    assign hit_iss = iss_en_i && (iss_addr_i == addr) && !flush_i;

    // A matching writeback hides the stale value and its busy flag, unless a
    // new producer for the same register issues in this very cycle.
    always_comb begin
      data_c = '0;
      busy_c = 1'b0;
      if (rst_ni && (addr != '0)) begin
        if (hit_wb) begin
          data_c = wb_data_i;
          busy_c = hit_iss ? busy_q[addr] : 1'b0;
        end else begin
          data_c = regs_q[addr];
          busy_c = busy_q[addr];
        end
      end
    end

    if (RD_LAT == 0) begin : g_comb
      assign rs_data_o[i*XLEN +: XLEN] = data_c;
      assign rs_busy_o[i]              = busy_c;
    end else begin : g_reg
      logic [XLEN-1:0] rd_data_q;
      logic            rd_busy_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rd_data_q <= '0;
          rd_busy_q <= 1'b0;
        end else begin
          rd_data_q <= data_c;
          rd_busy_q <= busy_c;
        end
      end

      assign rs_data_o[i*XLEN +: XLEN] = rd_data_q;
      assign rs_busy_o[i]              = rd_busy_q;
    end
  end

endmodule
